// File: rtl/wm_cycle_ctrl.sv
// Washing-machine cycle controller: fill/wash/drain/rinse/spin with pause, door interlock and abort.
// Define WM_PREWASH_EN to add a PREWASH phase ahead of the first FILL in heavy mode (mode 2).
module wm_cycle_ctrl #(
  parameter int CNT_W       = 8,
  parameter int FILL_CYC    = 4,
  parameter int WASH_BASE   = 8,
  parameter int DRAIN_CYC   = 3,
  parameter int RINSE_CYC   = 6,
  parameter int SPIN_CYC    = 5,
  parameter int MAX_RINSE   = 3,
  parameter int PREWASH_CYC = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             pause,
  input  logic             door_open,
  input  logic             abort,
  output logic [3:0]       state,
  output logic             busy,
  output logic             water_valve,
  output logic             drain_pump,
  output logic [1:0]       motor,
  output logic [CNT_W-1:0] phase_left,
  output logic [2:0]       rinse_left,
  output logic             paused,
  output logic             done
);

  // state   | meaning
  // IDLE    | waiting for start with door closed
  // FILL    | water valve open
  // WASH    | agitate for k*WASH_BASE cycles
  // DRAIN   | pump out; exits to FILL, SPIN, or IDLE after abort
  // RINSE   | agitate, consumes one rinse on exit
  // SPIN    | final spin
  // DONE    | one-cycle completion pulse
  // PREWASH | heavy-mode prewash (WM_PREWASH_EN only)
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FILL  = 4'd1,
    S_WASH  = 4'd2,
    S_DRAIN = 4'd3,
    S_RINSE = 4'd4,
    S_SPIN  = 4'd5,
    S_DONE  = 4'd6
`ifdef WM_PREWASH_EN
    , S_PREWASH = 4'd7
`endif
  } st_t;

  localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_CYC - 1);
  localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_CYC - 1);
`ifdef WM_PREWASH_EN
  localparam logic [CNT_W-1:0] PW_LD    = CNT_W'(PREWASH_CYC - 1);
`endif

  st_t              st_q, st_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [2:0]       rinse_q, rinse_d;
  logic [1:0]       mode_q, mode_d;
  logic             washed_q, washed_d;
  logic             abort_q, abort_d;
  logic             frozen;
  logic [CNT_W-1:0] wash_ld;
  logic [2:0]       rinse_init;

  assign busy   = (st_q != S_IDLE) && (st_q != S_DONE);
  assign frozen = busy && (pause || door_open);

  always_comb begin
    case (mode_q)
      2'd0:    wash_ld = CNT_W'(WASH_BASE - 1);
      2'd1:    wash_ld = CNT_W'(2 * WASH_BASE - 1);
      default: wash_ld = CNT_W'(3 * WASH_BASE - 1);
    endcase
    case (mode)
      2'd1:    rinse_init = 3'd2;
      2'd2:    rinse_init = 3'(MAX_RINSE);
      default: rinse_init = 3'd1;
    endcase
  end

  always_comb begin
    st_d     = st_q;
    tmr_d    = tmr_q;
    rinse_d  = rinse_q;
    mode_d   = mode_q;
    washed_d = washed_q;
    abort_d  = abort_q;
    case (st_q)
      S_IDLE: begin
        if (start && !door_open) begin
          mode_d   = mode;
          rinse_d  = rinse_init;
          washed_d = 1'b0;
          abort_d  = 1'b0;
`ifdef WM_PREWASH_EN
          if (mode == 2'd2) begin
            st_d  = S_PREWASH;
            tmr_d = PW_LD;
          end else
`endif
          begin
            st_d  = S_FILL;
            tmr_d = FILL_LD;
          end
        end
      end
      S_DONE: st_d = S_IDLE;
      default: begin
        abort_d = abort_q | abort;
        // Abort outranks freeze: leave any non-DRAIN phase for a full drain.
        if (abort && st_q != S_DRAIN) begin
          st_d  = S_DRAIN;
          tmr_d = DRAIN_LD;
        end else if (!frozen) begin
          if (tmr_q != '0) begin
            tmr_d = tmr_q - CNT_W'(1);
          end else begin
            case (st_q)
`ifdef WM_PREWASH_EN
              S_PREWASH: begin
                st_d  = S_FILL;
                tmr_d = FILL_LD;
              end
`endif
              S_FILL: begin
                if (!washed_q && mode_q != 2'd3) begin
                  st_d     = S_WASH;
                  tmr_d    = wash_ld;
                  washed_d = 1'b1;
                end else begin
                  st_d  = S_RINSE;
                  tmr_d = RINSE_LD;
                end
              end
              S_WASH: begin
                st_d  = S_DRAIN;
                tmr_d = DRAIN_LD;
              end
              S_RINSE: begin
                st_d    = S_DRAIN;
                tmr_d   = DRAIN_LD;
                rinse_d = rinse_q - 3'd1;
              end
              S_DRAIN: begin
                if (abort_q || abort) begin
                  st_d    = S_IDLE;
                  tmr_d   = '0;
                  rinse_d = 3'd0;
                  abort_d = 1'b0;
                end else if (rinse_q != 3'd0) begin
                  st_d  = S_FILL;
                  tmr_d = FILL_LD;
                end else begin
                  st_d  = S_SPIN;
                  tmr_d = SPIN_LD;
                end
              end
              S_SPIN: begin
                st_d    = S_DONE;
                tmr_d   = '0;
                rinse_d = 3'd0;
              end
              default: st_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= S_IDLE;
      tmr_q    <= '0;
      rinse_q  <= 3'd0;
      mode_q   <= 2'd0;
      washed_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      tmr_q    <= tmr_d;
      rinse_q  <= rinse_d;
      mode_q   <= mode_d;
      washed_q <= washed_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    water_valve = 1'b0;
    drain_pump  = 1'b0;
    motor       = 2'b00;
    if (!frozen) begin
      case (st_q)
        S_FILL:  water_valve = 1'b1;
        S_DRAIN: drain_pump  = 1'b1;
        S_WASH,
        S_RINSE: motor       = 2'b01;
        S_SPIN:  motor       = 2'b10;
`ifdef WM_PREWASH_EN
        S_PREWASH: begin
          water_valve = 1'b1;
          motor       = 2'b01;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state      = st_q;
  assign phase_left = tmr_q;
  assign rinse_left = rinse_q;
  assign paused     = frozen;
  assign done       = (st_q == S_DONE);

endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// Testbench for wm_cycle_ctrl: directed timing scenarios plus randomized stimulus
// against a phase-list reference model. Honors WM_PREWASH_EN like the design.
module tb_wm_cycle_ctrl;

  localparam int FILL_CYC    = 4;
  localparam int WASH_BASE   = 8;
  localparam int DRAIN_CYC   = 3;
  localparam int RINSE_CYC   = 6;
  localparam int SPIN_CYC    = 5;
  localparam int MAX_RINSE   = 3;
  localparam int PREWASH_CYC = 6;

  localparam int T_IDLE = 0, T_FILL = 1, T_WASH = 2, T_DRAIN = 3;
  localparam int T_RINSE = 4, T_SPIN = 5, T_DONE = 6, T_PREWASH = 7;

  logic       clk = 1'b0;
  logic       rst, start, pause, door_open, abort;
  logic [1:0] mode;
  logic [3:0] state;
  logic       busy, water_valve, drain_pump, paused, done;
  logic [1:0] motor;
  logic [7:0] phase_left;
  logic [2:0] rinse_left;

  int n_pass  = 0;
  int n_total = 0;

  wm_cycle_ctrl #(
    .CNT_W(8), .FILL_CYC(FILL_CYC), .WASH_BASE(WASH_BASE), .DRAIN_CYC(DRAIN_CYC),
    .RINSE_CYC(RINSE_CYC), .SPIN_CYC(SPIN_CYC), .MAX_RINSE(MAX_RINSE), .PREWASH_CYC(PREWASH_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pause(pause),
    .door_open(door_open), .abort(abort), .state(state), .busy(busy),
    .water_valve(water_valve), .drain_pump(drain_pump), .motor(motor),
    .phase_left(phase_left), .rinse_left(rinse_left), .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: the cycle is a list of (phase, duration) entries walked in order.
  int ph_st[$];
  int ph_len[$];
  int m_st, m_idx, m_cnt;
  bit m_ab;

  function automatic void m_reset();
    m_st = T_IDLE; m_idx = 0; m_cnt = 0; m_ab = 0;
    ph_st.delete(); ph_len.delete();
  endfunction

  function automatic void m_push(int s, int l);
    ph_st.push_back(s);
    ph_len.push_back(l);
  endfunction

  function automatic void m_build(int md);
    int k, r;
    ph_st.delete(); ph_len.delete();
    k = (md == 3) ? 0 : md + 1;
    r = (md == 1) ? 2 : (md == 2) ? MAX_RINSE : 1;
`ifdef WM_PREWASH_EN
    if (md == 2) m_push(T_PREWASH, PREWASH_CYC);
`endif
    if (k > 0) begin
      m_push(T_FILL, FILL_CYC); m_push(T_WASH, k * WASH_BASE); m_push(T_DRAIN, DRAIN_CYC);
    end
    for (int i = 0; i < r; i++) begin
      m_push(T_FILL, FILL_CYC); m_push(T_RINSE, RINSE_CYC); m_push(T_DRAIN, DRAIN_CYC);
    end
    m_push(T_SPIN, SPIN_CYC);
  endfunction

  function automatic void m_step();
    if (rst) begin
      m_reset();
    end else if (m_st == T_IDLE) begin
      if (start && !door_open) begin
        m_build(int'(mode));
        m_idx = 0; m_st = ph_st[0]; m_cnt = ph_len[0] - 1; m_ab = 0;
      end
    end else if (m_st == T_DONE) begin
      m_reset();
    end else if (abort && m_st != T_DRAIN) begin
      m_st = T_DRAIN; m_cnt = DRAIN_CYC - 1; m_ab = 1;
    end else begin
      if (abort) m_ab = 1;
      if (!(pause || door_open)) begin
        if (m_cnt > 0) m_cnt--;
        else if (m_ab) m_reset();
        else if (m_idx == ph_st.size() - 1) begin
          m_reset(); m_st = T_DONE;
        end else begin
          m_idx++; m_st = ph_st[m_idx]; m_cnt = ph_len[m_idx] - 1;
        end
      end
    end
  endfunction

  function automatic logic [21:0] m_exp();
    logic bz, fz, v, p;
    logic [1:0] mo;
    int rc;
    bz = (m_st != T_IDLE) && (m_st != T_DONE);
    fz = bz && (pause || door_open);
    v  = !fz && (m_st == T_FILL || m_st == T_PREWASH);
    p  = !fz && (m_st == T_DRAIN);
    mo = fz ? 2'b00 : (m_st == T_WASH || m_st == T_RINSE || m_st == T_PREWASH) ? 2'b01 :
         (m_st == T_SPIN) ? 2'b10 : 2'b00;
    rc = 0;
    if (bz) for (int i = m_idx; i < ph_st.size(); i++) if (ph_st[i] == T_RINSE) rc++;
    return {4'(m_st), bz, v, p, mo, (bz ? 8'(m_cnt) : 8'd0), 3'(rc), fz, (m_st == T_DONE)};
  endfunction

  function automatic logic [21:0] obs();
    return {state, busy, water_valve, drain_pump, motor, phase_left, rinse_left, paused, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; mode = 0; pause = 0; door_open = 0; abort = 0;
    m_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if (obs() !== 22'd0) $display("FAIL reset_outputs got %h want %h", obs(), 22'd0);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (obs() !== m_exp()) $display("FAIL reset_idle got %h want %h", obs(), m_exp());
    else n_pass++;
  endtask

  task automatic test_modes();
    int exp_done[4];
    int ck_n[6];
    int ck_s[6];
    int n, dn;
    exp_done = '{33, 54, 75, 18};
`ifdef WM_PREWASH_EN
    exp_done[2] = 81;
`endif
    ck_n = '{4, 12, 15, 19, 25, 28};
    ck_s = '{T_WASH, T_DRAIN, T_FILL, T_RINSE, T_DRAIN, T_SPIN};
    for (int md = 0; md < 4; md++) begin
      start = 1; mode = 2'(md);
      tick();
      n_total++;
      if (obs() !== m_exp()) $display("FAIL mode_start m%0d got %h want %h", md, obs(), m_exp());
      else n_pass++;
      n = 0; dn = -1;
      while (n < 200 && dn < 0) begin
        start = 1'($urandom_range(0, 1)); mode = 2'($urandom);
        tick(); n++;
        n_total++;
        if (obs() !== m_exp()) $display("FAIL mode_trace m%0d n%0d got %h want %h", md, n, obs(), m_exp());
        else n_pass++;
        if (md == 0) for (int j = 0; j < 6; j++) if (n == ck_n[j]) begin
          n_total++;
          if (state !== 4'(ck_s[j])) $display("FAIL mode0_phase n%0d got %0d want %0d", n, state, ck_s[j]);
          else n_pass++;
        end
        if (done === 1'b1) dn = n;
      end
      start = 0;
      n_total++;
      if (dn != exp_done[md]) $display("FAIL mode_done_edge m%0d got %0d want %0d", md, dn, exp_done[md]);
      else n_pass++;
      tick();
      n_total++;
      if (state !== 4'd0 || obs() !== m_exp()) $display("FAIL mode_back_idle m%0d got %h want %h", md, obs(), m_exp());
      else n_pass++;
    end
  endtask

  task automatic test_pause();
    int n, dn;
    start = 1; mode = 0;
    tick();
    start = 0; n = 0; dn = -1;
    while (n < 200 && dn < 0) begin
      tick(); n++;
      n_total++;
      if (obs() !== m_exp()) $display("FAIL pause_trace n%0d got %h want %h", n, obs(), m_exp());
      else n_pass++;
      if (n >= 6 && n <= 12) begin
        n_total++;
        if (paused !== 1'b1 || motor !== 2'b00 || phase_left !== 8'd6 || state !== 4'(T_WASH))
          $display("FAIL pause_hold n%0d got p%0b m%0d pl%0d s%0d want p1 m0 pl6 s2", n, paused, motor, phase_left, state);
        else n_pass++;
      end
      if (done === 1'b1) dn = n;
      pause = (n >= 5 && n <= 11);
    end
    pause = 0;
    n_total++;
    if (dn != 40) $display("FAIL pause_done_edge got %0d want 40", dn);
    else n_pass++;
    tick();
  endtask

  task automatic test_door();
    door_open = 1; start = 1; mode = 2'($urandom);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (state !== 4'd0 || obs() !== m_exp()) $display("FAIL door_block got %h want %h", obs(), m_exp());
      else n_pass++;
    end
    door_open = 0; start = 0;
    tick();
  endtask

  task automatic test_abort();
    int n, idle_n;
    bit seen_done;
    start = 1; mode = 1;
    tick();
    start = 0; n = 0; idle_n = -1; seen_done = 0;
    while (n < 100 && idle_n < 0) begin
      abort = (n == 19);
      tick(); n++;
      n_total++;
      if (obs() !== m_exp()) $display("FAIL abort_trace n%0d got %h want %h", n, obs(), m_exp());
      else n_pass++;
      if (done === 1'b1) seen_done = 1;
      if (state === 4'd0) idle_n = n;
    end
    abort = 0;
    n_total++;
    if (idle_n != 23 || seen_done) $display("FAIL abort_exit got idle@%0d done%0b want idle@23 done0", idle_n, seen_done);
    else n_pass++;
  endtask

  task automatic test_rst_mid_spin();
    int n, dn;
    start = 1; mode = 3;
    tick();
    start = 0;
    repeat (15) tick();
    n_total++;
    if (state !== 4'(T_SPIN)) $display("FAIL rst_pre_spin got %0d want %0d", state, T_SPIN);
    else n_pass++;
    #2 rst = 1;
    #1;
    m_reset();
    n_total++;
    if (obs() !== 22'd0) $display("FAIL rst_async got %h want %h", obs(), 22'd0);
    else n_pass++;
    tick();
    rst = 0;
    start = 1; mode = 3;
    tick();
    start = 0; n = 0; dn = -1;
    while (n < 100 && dn < 0) begin
      tick(); n++;
      n_total++;
      if (obs() !== m_exp()) $display("FAIL rst_restart n%0d got %h want %h", n, obs(), m_exp());
      else n_pass++;
      if (done === 1'b1) dn = n;
    end
    n_total++;
    if (dn != 18) $display("FAIL rst_restart_done got %0d want 18", dn);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      mode      = 2'($urandom);
      pause     = ($urandom_range(0, 9) == 0);
      door_open = ($urandom_range(0, 15) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
      n_total++;
      if (obs() !== m_exp()) $display("FAIL random i%0d got %h want %h", i, obs(), m_exp());
      else n_pass++;
    end
    start = 0; pause = 0; door_open = 0; abort = 0; rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; mode = 0; pause = 0; door_open = 0; abort = 0;
    test_reset();
    test_modes();
    test_pause();
    test_door();
    test_abort();
    test_rst_mid_spin();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
